// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply memory sequencer.
package matmul_pkg;

   localparam int unsigned DEF_DW = 32;
   localparam int unsigned DEF_AW = 7;

   typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

   // Row-major word address of element (row, col) in an n x n matrix.
   function automatic int unsigned rc_addr(input int unsigned row, input int unsigned col,
                                           input int unsigned n);
      return row * n + col;
   endfunction

   // Counter width that still holds n-1; never zero so N=1 stays legal.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matmul_idx_counter.sv
// Nested i/j/k index counter: k steps inside a dot product, (i,j) steps per result element.
module matmul_idx_counter
   import matmul_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned CW = cnt_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          step_k,
   input  logic          step_ij,
   output logic [CW-1:0] i,
   output logic [CW-1:0] j,
   output logic [CW-1:0] k,
   output logic          k_last,
   output logic          ij_last
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   assign k_last  = (k == LAST);
   assign ij_last = (i == LAST) && (j == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (clear) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else begin
         if (step_k) begin
            k <= k + CW'(1);
         end
         if (step_ij) begin
            k <= '0;
            if (j != LAST) begin
               j <= j + CW'(1);
            end else begin
               j <= '0;
               // Wrapping after the final element leaves the addresses at 0 for IDLE.
               i <= (i != LAST) ? i + CW'(1) : '0;
            end
         end
      end
   end

endmodule

// File: rtl/matmul_mem_ctrl.sv
// Sequencer for C = A x B over row-major NxN matrices in word-addressed memories.
module matmul_mem_ctrl
   import matmul_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned DW = DEF_DW,
   parameter int unsigned AW = DEF_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   output logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic [AW-1:0] c_addr,
   output logic [DW-1:0] c_data,
   output logic          c_we
);

   localparam int unsigned CW = cnt_width(N);

   state_t        state;
   logic [DW-1:0] acc;
   logic [DW-1:0] prod;
   logic [CW-1:0] i, j, k;
   logic          k_last, ij_last;
   logic          clear, step_k, step_ij;

   assign prod    = a_data * b_data;
   assign clear   = (state == IDLE) && start;
   assign step_k  = (state == MAC) && !k_last;
   assign step_ij = (state == WRITE);

   matmul_idx_counter #(
      .N  (N),
      .CW (CW)
   ) u_idx (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .step_k  (step_k),
      .step_ij (step_ij),
      .i       (i),
      .j       (j),
      .k       (k),
      .k_last  (k_last),
      .ij_last (ij_last)
   );

   assign a_addr = (state == MAC)   ? AW'(rc_addr(32'(i), 32'(k), N)) : '0;
   assign b_addr = (state == MAC)   ? AW'(rc_addr(32'(k), 32'(j), N)) : '0;
   assign c_addr = (state == WRITE) ? AW'(rc_addr(32'(i), 32'(j), N)) : '0;
   assign c_data = c_we ? acc : '0;

   // busy/done/c_we are registered alongside the state so they align with it exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         c_we  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc + prod;
               if (k_last) begin
                  c_we  <= 1'b1;
                  state <= WRITE;
               end
            end
            WRITE: begin
               acc  <= '0;
               c_we <= 1'b0;
               if (ij_last) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= MAC;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_mem_ctrl.sv
// Directed bench: three sequencer instances (N=1,2,3) with behavioural A/B memories.
module tb_matmul_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start  [3];
   logic        busy   [3];
   logic        done   [3];
   logic        c_we   [3];
   logic [6:0]  a_addr [3];
   logic [6:0]  b_addr [3];
   logic [6:0]  c_addr [3];
   logic [31:0] a_data [3];
   logic [31:0] b_data [3];
   logic [31:0] c_data [3];
   logic [31:0] a_mem  [3][100];
   logic [31:0] b_mem  [3][100];
   logic [31:0] cmem   [100];
   logic [31:0] exp_c  [9];

   int checks = 0;
   int errors = 0;
   int busy_cnt, we_cnt, done_cyc;
   int we_cyc [16];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign a_data[g] = a_mem[g][a_addr[g]];
      assign b_data[g] = b_mem[g][b_addr[g]];
      matmul_mem_ctrl #(
         .N  (g + 1),
         .DW (32),
         .AW (7)
      ) u_dut (
         .clk    (clk),
         .rst    (rst),
         .start  (start[g]),
         .busy   (busy[g]),
         .done   (done[g]),
         .a_addr (a_addr[g]),
         .a_data (a_data[g]),
         .b_addr (b_addr[g]),
         .b_data (b_data[g]),
         .c_addr (c_addr[g]),
         .c_data (c_data[g]),
         .c_we   (c_we[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts instance s and watches it until done (bounded), capturing C writes.
   task automatic run(input int s, input bit hold);
      int n = s + 1;
      busy_cnt = 0;
      we_cnt   = 0;
      done_cyc = 0;
      for (int e = 0; e < 100; e++) cmem[e] = 32'hdead_beef;
      @(negedge clk);
      start[s] = 1'b1;
      for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
         @(negedge clk);
         if (!hold) start[s] = 1'b0;
         if (busy[s]) begin
            busy_cnt++;
            check("a_range", 32'(a_addr[s] < 7'(n * n)), 1);
            check("b_range", 32'(b_addr[s] < 7'(n * n)), 1);
         end
         if (c_we[s]) begin
            check("we_in_busy", 32'(busy[s]), 1);
            check($sformatf("we_addr%0d", we_cnt), 32'(c_addr[s]), 32'(we_cnt));
            if (we_cnt < 16) we_cyc[we_cnt] = busy_cnt;
            if (c_addr[s] < 7'd100) cmem[c_addr[s]] = c_data[s];
            we_cnt++;
         end
         if (done[s]) done_cyc = cyc;
      end
      if (done_cyc == 0) check("done_timeout", 0, 1);
   endtask

   task automatic check_run(input string tag, input int n);
      check({tag, "_busy_cnt"}, busy_cnt, n * n * (n + 1));
      check({tag, "_we_cnt"}, we_cnt, n * n);
      check({tag, "_done_cyc"}, done_cyc, n * n * (n + 1) + 1);
      for (int e = 0; e < n * n; e++) begin
         check($sformatf("%s_c%0d", tag, e), cmem[e], exp_c[e]);
         check($sformatf("%s_wecyc%0d", tag, e), we_cyc[e], (e + 1) * (n + 1));
      end
      @(negedge clk);
      check({tag, "_idle_busy"}, 32'(busy[n-1]), 0);
      check({tag, "_idle_done"}, 32'(done[n-1]), 0);
   endtask

   initial begin
      rst = 1'b1;
      for (int s = 0; s < 3; s++) begin
         start[s] = 1'b0;
         for (int e = 0; e < 100; e++) begin
            a_mem[s][e] = 32'd1;
            b_mem[s][e] = 32'd1;
         end
      end
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy[2]), 0);
      check("rst_done", 32'(done[2]), 0);
      check("rst_we", 32'(c_we[2]), 0);
      check("rst_a_addr", 32'(a_addr[2]), 0);
      check("rst_b_addr", 32'(b_addr[2]), 0);
      check("rst_c_addr", 32'(c_addr[2]), 0);
      check("rst_c_data", c_data[2], 0);
      rst = 1'b0;
      @(negedge clk);

      // N=3, all-ones memories: every dot product is 3.
      exp_c = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
      run(2, 1'b0);
      check_run("ones3", 3);

      // N=2, A times identity.
      a_mem[1][0:3] = '{1, 2, 3, 4};
      b_mem[1][0:3] = '{1, 0, 0, 1};
      exp_c = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      run(1, 1'b0);
      check_run("ident2", 2);

      // N=2, product 2^32 truncates to 0.
      a_mem[1][0:3] = '{32'h10000, 0, 0, 0};
      b_mem[1][0:3] = '{32'h10000, 0, 0, 0};
      exp_c = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      run(1, 1'b0);
      check_run("wrap2", 2);

      // N=2, general product with start held high throughout.
      a_mem[1][0:3] = '{1, 2, 3, 4};
      b_mem[1][0:3] = '{5, 6, 7, 8};
      exp_c = '{19, 22, 43, 50, 0, 0, 0, 0, 0};
      run(1, 1'b1);
      check("hold_busy_cnt", busy_cnt, 12);
      check("hold_we_cnt", we_cnt, 4);
      check("hold_done_cyc", done_cyc, 13);
      for (int e = 0; e < 4; e++) check($sformatf("hold_c%0d", e), cmem[e], exp_c[e]);
      @(negedge clk);
      check("hold_idle_busy", 32'(busy[1]), 0);
      @(negedge clk);
      check("hold_rerun_busy", 32'(busy[1]), 1);
      start[1] = 1'b0;
      busy_cnt = 1;
      done_cyc = 0;
      for (int cyc = 0; cyc < 40 && done_cyc == 0; cyc++) begin
         @(negedge clk);
         if (busy[1]) busy_cnt++;
         if (done[1]) done_cyc = 1;
      end
      check("rerun_done", done_cyc, 1);
      check("rerun_busy_cnt", busy_cnt, 12);
      @(negedge clk);
      check("rerun_idle", 32'(busy[1]), 0);

      // N=1 single element.
      a_mem[0][0] = 32'd7;
      b_mem[0][0] = 32'd6;
      exp_c = '{42, 0, 0, 0, 0, 0, 0, 0, 0};
      run(0, 1'b0);
      check_run("n1", 1);

      // N=3 asynchronous reset mid-MAC of the fourth element, then a clean rerun.
      for (int e = 0; e < 9; e++) begin
         a_mem[2][e] = 32'(e);
         b_mem[2][e] = (e % 4 == 0) ? 32'd1 : 32'd0;
      end
      @(negedge clk);
      start[2] = 1'b1;
      @(negedge clk);
      start[2] = 1'b0;
      for (int c = 1; c < 14; c++) @(negedge clk);
      check("pre_rst_busy", 32'(busy[2]), 1);
      #2 rst = 1'b1;
      #1;
      check("async_busy", 32'(busy[2]), 0);
      check("async_we", 32'(c_we[2]), 0);
      check("async_a_addr", 32'(a_addr[2]), 0);
      check("async_c_data", c_data[2], 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("post_rst_quiet", 32'(busy[2] | c_we[2] | done[2]), 0);
      end
      exp_c = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
      run(2, 1'b0);
      check_run("after_rst", 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
